fifo_word_downsizer: RTL and testbench



---
 rtl/fifo_word_downsizer_pkg.sv | 25 ++
 rtl/fifo_word_downsizer.sv | 82 ++++++++
 tb/tb_fifo_word_downsizer.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_word_downsizer_pkg.sv
// Shared definitions for the FIFO word width converters (downsizer and upsizer).
// Latency: n/a (types, constants and helpers only).
// Backpressure: n/a.
package fifo_word_downsizer_pkg;

    // Default geometry: a 32-bit word split into four 8-bit beats.
    localparam int DEF_INWIDTH    = 32;
    localparam int DEF_RATIO      = 4;
    localparam int DEF_CNTR_WIDTH = 2;
    localparam int OW             = DEF_INWIDTH / DEF_RATIO;

    // Beat index within a word for the default geometry.
    typedef logic [DEF_CNTR_WIDTH-1:0] beat_idx_t;

    // Diagnostic strings shared with the upsizer so log scraping stays consistent.
    localparam string MSG_DEQ_EMPTY  = "Dequeuing from empty downsizer";
    localparam string MSG_IDX_RANGE  = "Last-beat index out of range, clamped to ratio-1";
    localparam string MSG_BAD_PARAMS = "Illegal width converter parameters";

    // Word width must split evenly, at least two beats, and the counter must reach every beat.
    function automatic bit params_ok(input int inwidth, input int ratio, input int cntr_width);
        return (ratio >= 2) && ((inwidth % ratio) == 0) && ((1 << cntr_width) >= ratio);
    endfunction

endpackage

// File: rtl/fifo_word_downsizer.sv
// Pops wide words from an upstream FIFO and emits them as narrow beats, LS beat first.
// Latency: one cycle from upstream pop to beat 0 on D_OUT; one beat per cycle when streaming.
// Backpressure: DEQ=0 freezes the current beat; upstream is popped only when idle or on the last beat.
module fifo_word_downsizer
    import fifo_word_downsizer_pkg::*;
#(
    parameter int p1inwidth    = DEF_INWIDTH,
    parameter int p2ratio      = DEF_RATIO,
    parameter int p3cntr_width = DEF_CNTR_WIDTH
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic                          CLR,
    input  logic [p1inwidth-1:0]          IN_D,
    input  logic [p3cntr_width-1:0]       IN_LAST_IDX,
    input  logic                          IN_EMPTY_N,
    output logic                          IN_DEQ,
    output logic [p1inwidth/p2ratio-1:0]  D_OUT,
    output logic                          LAST,
    output logic                          EMPTY_N,
    input  logic                          DEQ
);

    localparam int BEAT_W = p1inwidth / p2ratio;
    localparam logic [p3cntr_width-1:0] MAX_IDX = p3cntr_width'(p2ratio - 1);

    logic [p1inwidth-1:0]    sh;
    logic [p3cntr_width-1:0] cnt;
    logic [p3cntr_width-1:0] lidx;
    logic                    hv;
    logic [p3cntr_width-1:0] load_idx;

    assign D_OUT   = sh[BEAT_W-1:0];
    assign EMPTY_N = hv;
    assign LAST    = hv && (cnt == lidx);

    // Pop upstream when idle, or when the final beat leaves this cycle so the next word follows with no bubble.
    assign IN_DEQ = IN_EMPTY_N && !CLR && !RST && (!hv || (DEQ && LAST));

    // Indices beyond the last beat would never be reached by the counter; clamp them.
    assign load_idx = (IN_LAST_IDX > MAX_IDX) ? MAX_IDX : IN_LAST_IDX;

    // Beat state: reset, flush, load a new word, shift out one beat, or go empty after the final beat.
    always_ff @(posedge CLK) begin
        if (RST) begin
            sh   <= '0;
            cnt  <= '0;
            lidx <= '0;
            hv   <= 1'b0;
        end else if (CLR) begin
            cnt <= '0;
            hv  <= 1'b0;
        end else if (IN_DEQ) begin
            sh   <= IN_D;
            lidx <= load_idx;
            cnt  <= '0;
            hv   <= 1'b1;
        end else if (DEQ && hv && !LAST) begin
            sh  <= sh >> BEAT_W;
            cnt <= cnt + 1'b1;
        end else if (DEQ && LAST) begin
            hv <= 1'b0;
        end
    end

`ifndef SYNTHESIS
    // Simulation-only diagnostics for bad configuration and upstream/downstream protocol misuse.
    always_ff @(posedge CLK) begin
        if (!params_ok(p1inwidth, p2ratio, p3cntr_width)) begin
            $error("%s", MSG_BAD_PARAMS);
            $finish;
        end
        if (!RST && !CLR && DEQ && !hv) begin
            $warning("%s", MSG_DEQ_EMPTY);
        end
        if (IN_DEQ && (IN_LAST_IDX > MAX_IDX)) begin
            $warning("%s", MSG_IDX_RANGE);
        end
    end
`endif

endmodule

// File: tb/tb_fifo_word_downsizer.sv
// Self-checking bench for fifo_word_downsizer: directed scenarios plus a randomized scoreboard run.
// Latency: checks beat 0 one cycle after the upstream pop.
// Backpressure: exercises DEQ stalls, CLR flushes and mid-word reset.
module tb_fifo_word_downsizer;

    localparam int IW = 32;
    localparam int R  = 4;
    localparam int CW = 2;
    localparam int BW = IW / R;

    typedef struct {
        logic [IW-1:0] d;
        int            li;
    } word_t;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          CLR = 1'b0;
    logic [IW-1:0] IN_D = '0;
    logic [CW-1:0] IN_LAST_IDX = '0;
    logic          IN_EMPTY_N = 1'b0;
    logic          IN_DEQ;
    logic [BW-1:0] D_OUT;
    logic          LAST;
    logic          EMPTY_N;
    logic          DEQ = 1'b0;

    word_t up_q[$];
    int tests_run    = 0;
    int tests_failed = 0;

    always #5 CLK = ~CLK;

    fifo_word_downsizer #(.p1inwidth(IW), .p2ratio(R), .p3cntr_width(CW)) dut (
        .CLK(CLK), .RST(RST), .CLR(CLR),
        .IN_D(IN_D), .IN_LAST_IDX(IN_LAST_IDX), .IN_EMPTY_N(IN_EMPTY_N), .IN_DEQ(IN_DEQ),
        .D_OUT(D_OUT), .LAST(LAST), .EMPTY_N(EMPTY_N), .DEQ(DEQ)
    );

    // Present the upstream FIFO head and control inputs mid-cycle, then let combinational outputs settle.
    task automatic drive(input logic deq, input logic clr, input logic rst);
        @(negedge CLK);
        RST = rst;
        CLR = clr;
        DEQ = deq;
        if (up_q.size() > 0) begin
            IN_EMPTY_N  = 1'b1;
            IN_D        = up_q[0].d;
            IN_LAST_IDX = CW'(up_q[0].li);
        end else begin
            IN_EMPTY_N  = 1'b0;
            IN_D        = $urandom;
            IN_LAST_IDX = CW'($urandom);
        end
        #1;
    endtask

    // The upstream FIFO pops its head on the coming edge when the DUT asks for it.
    task automatic pop_if_deq();
        if (IN_DEQ === 1'b1 && up_q.size() > 0) void'(up_q.pop_front());
    endtask

    task automatic do_reset();
        up_q.delete();
        drive(1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_reset();
        do_reset();
        drive(1'b0, 1'b0, 1'b0);
        tests_run++;
        if (EMPTY_N !== 1'b0 || LAST !== 1'b0 || D_OUT !== '0 || IN_DEQ !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset: EMPTY_N=%b LAST=%b D_OUT=%h IN_DEQ=%b, want 0 0 00 0", EMPTY_N, LAST, D_OUT, IN_DEQ);
        end
    endtask

    task automatic test_single();
        logic [IW-1:0] w = 32'hDDCCBBAA;
        int pulses = 0;
        do_reset();
        up_q.push_back('{w, 3});
        drive(1'b1, 1'b0, 1'b0);
        tests_run++;
        if (IN_DEQ !== 1'b1 || EMPTY_N !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_load: IN_DEQ=%b EMPTY_N=%b, want 1 0", IN_DEQ, EMPTY_N);
        end
        pulses += int'(IN_DEQ);
        pop_if_deq();
        for (int i = 0; i < R; i++) begin
            drive(1'b1, 1'b0, 1'b0);
            tests_run++;
            if (EMPTY_N !== 1'b1 || D_OUT !== w[BW*i +: BW] || LAST !== (i == R - 1)) begin
                tests_failed++;
                $display("FAIL single_beat%0d: D_OUT=%h LAST=%b EMPTY_N=%b, want %h %b 1",
                         i, D_OUT, LAST, EMPTY_N, w[BW*i +: BW], (i == R - 1));
            end
            pulses += int'(IN_DEQ);
            pop_if_deq();
        end
        drive(1'b0, 1'b0, 1'b0);
        tests_run++;
        if (EMPTY_N !== 1'b0 || pulses != 1) begin
            tests_failed++;
            $display("FAIL single_end: EMPTY_N=%b pulses=%0d, want 0 1", EMPTY_N, pulses);
        end
    endtask

    task automatic test_back_to_back();
        logic [2*IW-1:0] both = {32'h87654321, 32'hDDCCBBAA};
        do_reset();
        up_q.push_back('{both[IW-1:0], 3});
        up_q.push_back('{both[2*IW-1:IW], 3});
        drive(1'b1, 1'b0, 1'b0);
        tests_run++;
        if (IN_DEQ !== 1'b1) begin
            tests_failed++;
            $display("FAIL b2b_load: IN_DEQ=%b, want 1", IN_DEQ);
        end
        pop_if_deq();
        for (int i = 0; i < 2 * R; i++) begin
            drive(1'b1, 1'b0, 1'b0);
            tests_run++;
            if (EMPTY_N !== 1'b1 || D_OUT !== both[BW*i +: BW] || LAST !== ((i % R) == R - 1)
                || IN_DEQ !== (i == R - 1)) begin
                tests_failed++;
                $display("FAIL b2b_beat%0d: D_OUT=%h LAST=%b EMPTY_N=%b IN_DEQ=%b, want %h %b 1 %b",
                         i, D_OUT, LAST, EMPTY_N, IN_DEQ, both[BW*i +: BW], ((i % R) == R - 1), (i == R - 1));
            end
            pop_if_deq();
        end
        drive(1'b0, 1'b0, 1'b0);
        tests_run++;
        if (EMPTY_N !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_end: EMPTY_N=%b, want 0", EMPTY_N);
        end
    endtask

    task automatic test_partial();
        do_reset();
        up_q.push_back('{32'h44332211, 1});
        up_q.push_back('{32'hA1B2C3D4, 3});
        drive(1'b1, 1'b0, 1'b0);
        pop_if_deq();
        drive(1'b1, 1'b0, 1'b0);
        tests_run++;
        if (D_OUT !== 8'h11 || LAST !== 1'b0 || EMPTY_N !== 1'b1 || IN_DEQ !== 1'b0) begin
            tests_failed++;
            $display("FAIL partial_b0: D_OUT=%h LAST=%b EMPTY_N=%b IN_DEQ=%b, want 11 0 1 0", D_OUT, LAST, EMPTY_N, IN_DEQ);
        end
        pop_if_deq();
        drive(1'b1, 1'b0, 1'b0);
        tests_run++;
        if (D_OUT !== 8'h22 || LAST !== 1'b1 || IN_DEQ !== 1'b1) begin
            tests_failed++;
            $display("FAIL partial_b1: D_OUT=%h LAST=%b IN_DEQ=%b, want 22 1 1", D_OUT, LAST, IN_DEQ);
        end
        pop_if_deq();
        drive(1'b1, 1'b0, 1'b0);
        tests_run++;
        if (D_OUT !== 8'hD4 || LAST !== 1'b0 || EMPTY_N !== 1'b1) begin
            tests_failed++;
            $display("FAIL partial_next: D_OUT=%h LAST=%b EMPTY_N=%b, want d4 0 1", D_OUT, LAST, EMPTY_N);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        up_q.push_back('{32'hDDCCBBAA, 3});
        up_q.push_back('{32'h55667788, 3});
        drive(1'b1, 1'b0, 1'b0);
        pop_if_deq();
        drive(1'b1, 1'b0, 1'b0);
        pop_if_deq();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 1'b0);
            tests_run++;
            if (D_OUT !== 8'hBB || LAST !== 1'b0 || EMPTY_N !== 1'b1 || IN_DEQ !== 1'b0) begin
                tests_failed++;
                $display("FAIL stall%0d: D_OUT=%h LAST=%b EMPTY_N=%b IN_DEQ=%b, want bb 0 1 0", i, D_OUT, LAST, EMPTY_N, IN_DEQ);
            end
            pop_if_deq();
        end
        drive(1'b1, 1'b0, 1'b0);
        pop_if_deq();
        drive(1'b1, 1'b0, 1'b0);
        tests_run++;
        if (D_OUT !== 8'hCC || EMPTY_N !== 1'b1) begin
            tests_failed++;
            $display("FAIL stall_resume: D_OUT=%h EMPTY_N=%b, want cc 1", D_OUT, EMPTY_N);
        end
    endtask

    task automatic test_clr();
        do_reset();
        up_q.push_back('{32'hDDCCBBAA, 3});
        up_q.push_back('{32'h99887766, 3});
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 1'b0);
            pop_if_deq();
        end
        drive(1'b1, 1'b1, 1'b0);
        tests_run++;
        if (D_OUT !== 8'hCC || IN_DEQ !== 1'b0) begin
            tests_failed++;
            $display("FAIL clr_during: D_OUT=%h IN_DEQ=%b, want cc 0", D_OUT, IN_DEQ);
        end
        pop_if_deq();
        drive(1'b1, 1'b0, 1'b0);
        tests_run++;
        if (EMPTY_N !== 1'b0 || LAST !== 1'b0 || IN_DEQ !== 1'b1) begin
            tests_failed++;
            $display("FAIL clr_after: EMPTY_N=%b LAST=%b IN_DEQ=%b, want 0 0 1", EMPTY_N, LAST, IN_DEQ);
        end
        pop_if_deq();
        drive(1'b0, 1'b0, 1'b0);
        tests_run++;
        if (EMPTY_N !== 1'b1 || D_OUT !== 8'h66) begin
            tests_failed++;
            $display("FAIL clr_reload: EMPTY_N=%b D_OUT=%h, want 1 66", EMPTY_N, D_OUT);
        end
    endtask

    task automatic test_rst_mid();
        do_reset();
        up_q.push_back('{32'hDDCCBBAA, 3});
        up_q.push_back('{32'h12345678, 3});
        drive(1'b1, 1'b0, 1'b0);
        pop_if_deq();
        drive(1'b1, 1'b0, 1'b0);
        pop_if_deq();
        drive(1'b1, 1'b0, 1'b1);
        tests_run++;
        if (IN_DEQ !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_ideq: IN_DEQ=%b, want 0", IN_DEQ);
        end
        pop_if_deq();
        drive(1'b1, 1'b0, 1'b1);
        tests_run++;
        if (EMPTY_N !== 1'b0 || D_OUT !== '0 || LAST !== 1'b0 || IN_DEQ !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_state: EMPTY_N=%b D_OUT=%h LAST=%b IN_DEQ=%b, want 0 00 0 0", EMPTY_N, D_OUT, LAST, IN_DEQ);
        end
        up_q.delete();
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        tests_run++;
        if (EMPTY_N !== 1'b0 || D_OUT !== '0 || LAST !== 1'b0) begin
            tests_failed++;
            $display("FAIL deq_empty: EMPTY_N=%b D_OUT=%h LAST=%b, want 0 00 0", EMPTY_N, D_OUT, LAST);
        end
    endtask

    // Scoreboard: remaining beats of the word held by the DUT, derived from the words popped upstream.
    task automatic test_random();
        logic [BW-1:0] exp_q[$];
        logic          exp_last[$];
        do_reset();
        for (int c = 0; c < 600; c++) begin
            logic  deq;
            logic  exp_ideq;
            word_t w;
            deq = ($urandom_range(0, 3) != 0);
            drive(deq, 1'b0, 1'b0);
            exp_ideq = (up_q.size() > 0) && (exp_q.size() == 0 || (deq && exp_q.size() == 1));
            tests_run++;
            if (IN_DEQ !== exp_ideq || EMPTY_N !== (exp_q.size() > 0)) begin
                tests_failed++;
                $display("FAIL rand_ctl c%0d: IN_DEQ=%b EMPTY_N=%b, want %b %b", c, IN_DEQ, EMPTY_N, exp_ideq, (exp_q.size() > 0));
            end
            if (exp_q.size() > 0) begin
                tests_run++;
                if (D_OUT !== exp_q[0] || LAST !== exp_last[0]) begin
                    tests_failed++;
                    $display("FAIL rand_beat c%0d: D_OUT=%h LAST=%b, want %h %b", c, D_OUT, LAST, exp_q[0], exp_last[0]);
                end
                if (deq) begin
                    void'(exp_q.pop_front());
                    void'(exp_last.pop_front());
                end
            end
            if (IN_DEQ === 1'b1 && up_q.size() > 0) begin
                w = up_q.pop_front();
                for (int k = 0; k <= w.li; k++) begin
                    exp_q.push_back(w.d[BW*k +: BW]);
                    exp_last.push_back(k == w.li);
                end
            end
            if (up_q.size() < 3 && $urandom_range(0, 2) != 0)
                up_q.push_back('{$urandom, int'($urandom_range(0, R - 1))});
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_partial();
        test_backpressure();
        test_clr();
        test_rst_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
